// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types, widths and Gray decode helper for the Gray count checker
package gray_pkg;

  typedef enum logic [1:0] {
    WAIT_ZERO = 2'd0,
    TRACK     = 2'd1,
    ERR       = 2'd2
  } chk_state_t;

  localparam int GRAY_W = 4;

  // Each binary bit is the XOR of the Gray bits at and above it.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b = '0;
    for (int i = 0; i < GRAY_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_count_checker_if.sv
// rtl/gray_count_checker_if.sv - sample input and check result bundle of the Gray count checker
interface gray_count_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);

  logic [WIDTH-1:0] gray_in;
  logic             gray_valid;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             wrap_pulse;
  logic             step_err;
  logic [ERR_W-1:0] err_count;
  logic             locked;

  modport master (
    output gray_in,
    output gray_valid,
    input  bin_out,
    input  bin_valid,
    input  wrap_pulse,
    input  step_err,
    input  err_count,
    input  locked
  );

  modport slave (
    input  gray_in,
    input  gray_valid,
    output bin_out,
    output bin_valid,
    output wrap_pulse,
    output step_err,
    output err_count,
    output locked
  );

endinterface

// File: rtl/gray2bin_dec.sv
// rtl/gray2bin_dec.sv - combinational Gray to binary decoder
module gray2bin_dec #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_count_checker.sv
// rtl/gray_count_checker.sv - checks a sampled Gray counter for reset-to-zero and +1 steps
module gray_count_checker
  import gray_pkg::*;
#(
  parameter int WIDTH      = GRAY_W,
  parameter int ERR_W      = 8,
  parameter bit ALLOW_HOLD = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  gray_count_checker_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_BIN = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  chk_state_t       state_q;
  chk_state_t       state_d;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] next_bin;
  logic             bin_valid_q;
  logic             wrap_q;
  logic             err_q;
  logic [ERR_W-1:0] err_count_q;
  logic             wrap_d;
  logic             err_d;
  logic             is_succ;
  logic             is_hold;
  logic             legal_step;

  gray2bin_dec #(
    .WIDTH(WIDTH)
  ) u_dec (
    .gray(bus.gray_in),
    .bin (dec)
  );

  assign next_bin   = prev_bin + WIDTH'(1);
  assign is_succ    = (dec == next_bin);
  assign is_hold    = (dec == prev_bin);
  assign legal_step = is_succ || (ALLOW_HOLD && is_hold);

  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.gray_valid) begin
      unique case (state_q)
        WAIT_ZERO: begin
          if (dec == '0) begin
            state_d = TRACK;
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
        // A legal step out of ERR relocks exactly like a legal step in TRACK.
        TRACK, ERR: begin
          if (legal_step) begin
            state_d = TRACK;
            wrap_d  = is_succ && (prev_bin == MAX_BIN);
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
        default: state_d = WAIT_ZERO;
      endcase
    end
  end

  // prev_bin follows every valid sample so a glitch costs exactly two errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_ZERO;
      prev_bin    <= '0;
      bin_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      bin_valid_q <= bus.gray_valid;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
      if (bus.gray_valid) begin
        prev_bin <= dec;
      end
      if (err_d && (err_count_q != ERR_MAX)) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign bus.bin_out    = prev_bin;
  assign bus.bin_valid  = bin_valid_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.step_err   = err_q;
  assign bus.err_count  = err_count_q;
  assign bus.locked     = (state_q == TRACK);

endmodule

// File: tb/tb_gray_count_checker.sv
// tb/tb_gray_count_checker.sv - scoreboard bench for gray_count_checker, hold disallowed and allowed
module tb_gray_count_checker;

  typedef struct {
    int bin;
    bit wrap;
    bit err;
    int cnt;
    bit lck;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gray_in = '0;
  logic       gray_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   wraps0 = 0;

  // Reference state: one set per hold policy (index 0 = no hold, 1 = hold allowed).
  bit   m_wait[2];
  int   m_prev[2];
  int   m_cnt[2];

  gray_count_checker_if #(.WIDTH(4), .ERR_W(8)) if0 ();
  gray_count_checker_if #(.WIDTH(4), .ERR_W(8)) if1 ();

  assign if0.gray_in    = gray_in;
  assign if0.gray_valid = gray_valid;
  assign if1.gray_in    = gray_in;
  assign if1.gray_valid = gray_valid;

  gray_count_checker #(.WIDTH(4), .ERR_W(8), .ALLOW_HOLD(1'b0)) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(if0)
  );

  gray_count_checker #(.WIDTH(4), .ERR_W(8), .ALLOW_HOLD(1'b1)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(if1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] enc(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  // Decode by searching for the binary value whose Gray code matches.
  function automatic int dec_model(input logic [3:0] g);
    for (int b = 0; b < 16; b++) begin
      if (enc(b) == g) return b;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 1'b1;
      m_prev[k] = 0;
      m_cnt[k]  = 0;
    end
  endfunction

  function automatic exp_t model_step(input int k, input logic [3:0] g);
    exp_t e;
    int   d;
    bit   succ;
    bit   legal;
    d    = dec_model(g);
    succ = (d == (m_prev[k] + 1) % 16);
    if (m_wait[k]) legal = (d == 0);
    else legal = succ || (k == 1 && d == m_prev[k]);
    e.bin  = d;
    e.wrap = !m_wait[k] && legal && succ && (m_prev[k] == 15);
    e.err  = !legal;
    if (!legal && m_cnt[k] < 255) m_cnt[k]++;
    e.cnt  = m_cnt[k];
    e.lck  = legal;
    m_prev[k] = d;
    m_wait[k] = 1'b0;
    return e;
  endfunction

  task automatic drive(input bit v, input logic [3:0] g, input bit r);
    gray_in    = g;
    gray_valid = v;
    rst        = r;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (v) begin
      q0.push_back(model_step(0, g));
      q1.push_back(model_step(1, g));
    end
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if0.bin_valid) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_valid", 1, 0);
      end else begin
        e = q0.pop_front();
        check("dut0_bin_out", int'(if0.bin_out), e.bin);
        check("dut0_wrap", int'(if0.wrap_pulse), int'(e.wrap));
        check("dut0_step_err", int'(if0.step_err), int'(e.err));
        check("dut0_err_count", int'(if0.err_count), e.cnt);
        check("dut0_locked", int'(if0.locked), int'(e.lck));
        if (if0.wrap_pulse) wraps0++;
      end
    end else begin
      check("dut0_idle_pulses", int'({if0.wrap_pulse, if0.step_err}), 0);
    end
    if (if1.bin_valid) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_valid", 1, 0);
      end else begin
        e = q1.pop_front();
        check("dut1_bin_out", int'(if1.bin_out), e.bin);
        check("dut1_wrap", int'(if1.wrap_pulse), int'(e.wrap));
        check("dut1_step_err", int'(if1.step_err), int'(e.err));
        check("dut1_err_count", int'(if1.err_count), e.cnt);
        check("dut1_locked", int'(if1.locked), int'(e.lck));
      end
    end else begin
      check("dut1_idle_pulses", int'({if1.wrap_pulse, if1.step_err}), 0);
    end
  end

  initial begin
    int cur;
    int r;
    model_reset();

    // Reset state
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    check("reset_bin_out", int'(if0.bin_out), 0);
    check("reset_bin_valid", int'(if0.bin_valid), 0);
    check("reset_err_count", int'(if0.err_count), 0);
    check("reset_locked", int'(if0.locked), 0);
    check("reset_pulses", int'({if0.wrap_pulse, if0.step_err}), 0);

    // Clean count: 49 samples from zero give three wraps
    wraps0 = 0;
    for (int i = 0; i < 49; i++) drive(1'b1, enc(i % 16), 1'b0);
    settle();
    check("wrap_total", wraps0, 3);
    check("clean_err_count", int'(if0.err_count), 0);
    check("clean_locked", int'(if0.locked), 1);

    // Glitch at binary 5: 1111 then 0101 are both errors, 0100 relocks
    drive(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i <= 5; i++) drive(1'b1, enc(i), 1'b0);
    drive(1'b1, 4'b1111, 1'b0);
    drive(1'b1, 4'b0101, 1'b0);
    check("glitch_err_count", int'(if0.err_count), 2);
    check("glitch_locked", int'(if0.locked), 0);
    drive(1'b1, 4'b0100, 1'b0);
    check("glitch_relock", int'(if0.locked), 1);

    // Non-zero first sample, then resync on successor
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b1, 4'b0011, 1'b0);
    check("first_nonzero_err", int'(if0.step_err), 1);
    check("first_nonzero_cnt", int'(if0.err_count), 1);
    drive(1'b1, 4'b0010, 1'b0);
    check("first_nonzero_relock", int'(if0.locked), 1);

    // Hold policy
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b1, 4'b0000, 1'b0);
    drive(1'b1, 4'b0001, 1'b0);
    drive(1'b1, 4'b0001, 1'b0);
    check("hold_dis_err", int'(if0.step_err), 1);
    check("hold_en_err", int'(if1.step_err), 0);
    check("hold_en_valid", int'(if1.bin_valid), 1);

    // Saturation after 300 illegal samples
    drive(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 300; i++) drive(1'b1, (i % 2 == 0) ? 4'b1111 : 4'b0010, 1'b0);
    check("sat_count0", int'(if0.err_count), 255);
    check("sat_count1", int'(if1.err_count), 255);

    // Reset mid-stream with a valid sample present; the sample is discarded
    drive(1'b1, 4'b0110, 1'b1);
    check("midrst_bin_out", int'(if0.bin_out), 0);
    check("midrst_bin_valid", int'(if0.bin_valid), 0);
    check("midrst_err_count", int'(if0.err_count), 0);
    check("midrst_locked", int'(if0.locked), 0);
    drive(1'b1, 4'b0000, 1'b0);
    check("midrst_relock", int'(if0.locked), 1);
    check("midrst_cnt_zero", int'(if0.err_count), 0);

    // Randomised source: mostly clean steps with gaps, holds, glitches and resets
    cur = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) begin
        drive(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      end else if (r < 12) begin
        drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);
        cur = 15;
      end else if (r < 20) begin
        cur = $urandom_range(0, 15);
        drive(1'b1, enc(cur), 1'b0);
      end else if (r < 26) begin
        drive(1'b1, enc(cur), 1'b0);
      end else begin
        cur = (cur + 1) % 16;
        drive(1'b1, enc(cur), 1'b0);
      end
    end
    drive(1'b0, 4'b0000, 1'b0);
    settle();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_count_checker.md
Name: gray_count_checker

Overview:
- Receive-side companion to the 4-bit Gray code counter. Samples the counter's gray_count output each clock and decodes it to binary.
- Checks every sample against the counter's contract: reset to 0000, then one increment per sample, wrapping modulo 2^WIDTH.
- Reports decoded value, wrap events, step errors and a saturating error count. Sits beside the counter in the testbench harness or in-system as a protocol monitor.

Parameters:
- WIDTH, 4, Gray/binary word width.
- ERR_W, 8, error counter width.
- ALLOW_HOLD, 0, 1 = an unchanged sample is legal (counter stalled); 0 = unchanged sample is a step error.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- gray_in  input  WIDTH  sampled counter value (gray_count).
- gray_valid  input  1  gray_in is a valid sample this cycle.
- bin_out  output  WIDTH  registered binary decode of last valid sample.
- bin_valid  output  1  one-cycle pulse: bin_out updated.
- wrap_pulse  output  1  one-cycle pulse: legal step from max (all ones binary) to 0.
- step_err  output  1  one-cycle pulse: illegal sample detected.
- err_count  output  ERR_W  saturating count of step_err pulses.
- locked  output  1  high in TRACK state.

Behaviour:
- Reset (rst=1 at posedge): state=WAIT_ZERO; bin_out=0, bin_valid=0, wrap_pulse=0, step_err=0, err_count=0, locked=0; reference register prev_bin=0. rst dominates gray_valid in the same cycle; that sample is discarded.
- Decode: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i]. Purely combinational, in sub-module.
- Latency: sample valid at edge N -> bin_out/bin_valid/wrap_pulse/step_err valid after edge N (registered, 1 cycle). err_count reflects the error in the same cycle step_err is high.
- No sample (gray_valid=0): all pulses 0, bin_out, prev_bin and state hold.
- FSM states (enum in package):
  - WAIT_ZERO: first valid sample after reset. If decoded==0 -> TRACK. Otherwise -> step_err, go to ERR.
  - TRACK: a valid sample with decoded==prev_bin+1 mod 2^WIDTH is legal; stay in TRACK. If prev_bin==2^WIDTH-1 and decoded==0, also assert wrap_pulse. A sample with decoded==prev_bin is legal if ALLOW_HOLD=1, otherwise step_err. Any other value -> step_err, go to ERR.
  - ERR: the next valid sample that is a legal successor of prev_bin -> TRACK. An illegal sample -> step_err again, stay in ERR.
- All states: bin_out and prev_bin load the decoded value on every valid sample, legal or not. The checker therefore resynchronises to the new value; a single glitched sample produces exactly 2 errors (into and out of the glitch).
- locked = (state==TRACK), registered.
- err_count increments on each step_err and saturates at 2^ERR_W-1; it does not wrap. It clears only on rst.
- Multi-bit Gray change (Hamming distance >1) is always illegal: it cannot decode to the +1 successor.
- Reset mid-operation: checker returns to WAIT_ZERO; the counter's next post-reset 0000 relocks it without error.

Decomposition:
- gray_pkg:
  - typedef enum logic [1:0] chk_state_t {WAIT_ZERO, TRACK, ERR}.
  - localparam GRAY_W=4.
  - Function gray2bin() for bench reference-model reuse.
- Sub-module gray2bin_dec: parameterised WIDTH, combinational Gray->binary, instantiated once.
- Top holds FSM, prev_bin, output registers, saturating counter.

Test Plan:
- Reset then 16 consecutive valid samples 0000,0001,0011,...,1000 -> bin_out 0..15 in order, locked=1 after first sample, step_err never asserted, err_count=0.
- Continue to 17th sample 0000 -> wrap_pulse=1 for exactly one cycle with bin_out=0; a further 32 samples give 2 further wrap pulses.
- In TRACK at binary 5 (0111), inject 1111 (bin 10) then resume 0101 (bin 6) -> step_err pulses on both samples, err_count=2, locked=0 after the glitch; the following sample 0100 (bin 7) -> locked=1.
- First post-reset sample 0011 -> step_err=1, state ERR, err_count=1; next sample 0010 (bin 3, successor of 2) -> locked=1.
- ALLOW_HOLD=0: sample 0001 twice -> step_err on the second sample. ALLOW_HOLD=1: same stimulus -> no error, bin_valid pulses both times.
- Force 300 illegal samples with ERR_W=8 -> err_count stops at 255. Assert rst mid-stream -> all outputs 0 next cycle; then 0000 -> locked=1, err_count=0.
